// File: rtl/cpu_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_fetch_pkg
// Description : Shared constants and types for the F32 instruction fetch stage:
//               NOP encoding, instruction size, fetch FSM states, queue entry.
//               Queue depth follows the FETCH_PREFETCH_EN build macro.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_fetch_pkg;

    // All-zero word decodes to op 0, used as the bubble instruction
    localparam logic [31:0] c_NOP_INSTR   = 32'h0000_0000;
    localparam int          c_INSTR_BYTES = 4;

`ifdef FETCH_PREFETCH_EN
    // Two entries let requests run ahead of consumption
    localparam int c_FETCH_DEPTH = 2;
`else
    // Single entry: refill only when empty or being drained this cycle
    localparam int c_FETCH_DEPTH = 1;
`endif

    localparam int c_QCW = $clog2(c_FETCH_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Sequential PC step; unsigned wrap at the top of the address space
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'(c_INSTR_BYTES);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_fetch_if
// Description : Bundle of pipeline-control, decoder-output and instruction
//               memory req/ack signals of the fetch stage. The master modport
//               is the fetch stage; the slave modport is its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_fetch_if;
    import cpu_fetch_pkg::*;

    logic        stall;
    logic        p2_pipeline_bubble;
    logic        p3_jump;
    logic [31:0] p3_jump_target;
    logic [31:0] p2_instr;
    logic [31:0] p2_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        input  stall,
        input  p2_pipeline_bubble,
        input  p3_jump,
        input  p3_jump_target,
        output p2_instr,
        output p2_pc,
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        output stall,
        output p2_pipeline_bubble,
        output p3_jump,
        output p3_jump_target,
        input  p2_instr,
        input  p2_pc,
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/cpu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Small shift-register FIFO of {instr, pc} entries. Head sits in
//               slot 0; a pop shifts every slot down by one. Flush beats push.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import cpu_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  wire logic         clock,
    input  wire logic         reset,
    input  wire logic         i_push,
    input  wire logic         i_pop,
    input  wire logic         i_flush,
    input  wire fetch_entry_t i_data,
    output fetch_entry_t      o_head,
    output logic              o_empty,
    output logic              o_full,
    output logic [CW-1:0]     o_free
);

    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_wr_idx;
    fetch_entry_t  w_slot_q [DEPTH];

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CW'(DEPTH));
    assign o_free   = CW'(DEPTH) - r_count;
    assign o_head   = w_slot_q[0];

    assign w_pop    = i_pop && !o_empty;
    // A push into a full queue is accepted only if the head leaves this cycle
    assign w_push   = i_push && (!o_full || w_pop);
    // After a same-cycle pop the tail moves down one slot
    assign w_wr_idx = r_count - CW'(w_pop);

    // Occupancy count; flush wins over any push or pop
    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        fetch_entry_t r_slot;
        fetch_entry_t w_shift_in;

        assign w_slot_q[gi] = r_slot;

        if (gi < DEPTH - 1) begin : g_mid
            assign w_shift_in = w_slot_q[gi+1];
        end else begin : g_tail
            assign w_shift_in = r_slot;
        end

        // Slot payload: new data lands at the tail, otherwise shift on pop
        always_ff @(posedge clock) begin
            if (w_push && (w_wr_idx == CW'(gi))) begin
                r_slot <= i_data;
            end else if (w_pop) begin
                r_slot <= w_shift_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : cpu_fetch
// Description : F32 instruction fetch stage. Generates the PC, fetches words
//               over a single-outstanding req/ack memory port, buffers them in
//               fetch_queue and presents one instruction per cycle on p2.
//               Build macro FETCH_PREFETCH_EN selects a 2-entry prefetching
//               queue; without it the queue holds one entry.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_fetch
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'hFFFF_0000
) (
    input  wire logic  clock,
    input  wire logic  reset,
    cpu_fetch_if.master bus
);

    fetch_state_t      r_state;
    logic [31:0]       r_fetch_pc;
    logic [31:0]       r_req_addr;

    fetch_entry_t      w_q_head;
    fetch_entry_t      w_push_data;
    logic              w_q_empty;
    logic              w_q_full;
    logic [c_QCW-1:0]  w_q_free;
    logic              w_pop;
    logic              w_push;
    logic              w_jump;
    logic              w_slot_free;
    logic              w_req;
    logic [31:0]       w_addr;
    logic              w_acked;

    // Jumps act only when the pipeline is moving; they always block a pop
    assign w_jump = bus.p3_jump && !bus.stall;
    assign w_pop  = !bus.stall && !bus.p2_pipeline_bubble && !bus.p3_jump && !w_q_empty;

`ifdef FETCH_PREFETCH_EN
    // Run ahead whenever any slot is free, including one freed right now
    assign w_slot_free = (w_q_free != '0) || w_pop;
`else
    // Refill only when the single entry is absent or leaving this cycle
    assign w_slot_free = (w_q_free == c_QCW'(c_FETCH_DEPTH)) || w_pop;
`endif

    // Request line: new requests from IDLE, held requests in WAIT/DISCARD
    always_comb begin
        w_req = 1'b0;
        case (r_state)
            ST_IDLE:    w_req = w_slot_free;
            ST_WAIT:    w_req = 1'b1;
            ST_DISCARD: w_req = 1'b1;
            default:    w_req = 1'b0;
        endcase
        if (reset) begin
            w_req = 1'b0;
        end
    end

    // A held request keeps its original address even after a redirect
    assign w_addr      = (r_state == ST_IDLE) ? r_fetch_pc : r_req_addr;
    assign w_acked     = w_req && bus.imem_ack;
    assign w_push      = w_acked && (r_state != ST_DISCARD) && !w_jump
                         && (!w_q_full || w_pop);
    assign w_push_data = {bus.imem_rdata, w_addr};

    fetch_queue #(
        .DEPTH (c_FETCH_DEPTH),
        .CW    (c_QCW)
    ) u_queue (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_jump),
        .i_data  (w_push_data),
        .o_head  (w_q_head),
        .o_empty (w_q_empty),
        .o_full  (w_q_full),
        .o_free  (w_q_free)
    );

    // Request FSM and fetch PC; a taken jump overrides any PC advance
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_ADDR;
            r_req_addr <= RESET_ADDR;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_req_addr <= r_fetch_pc;
                        if (w_acked) begin
                            r_fetch_pc <= pc_inc(r_fetch_pc);
                        end else begin
                            r_state <= w_jump ? ST_DISCARD : ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_acked) begin
                        r_state    <= ST_IDLE;
                        r_fetch_pc <= pc_inc(r_fetch_pc);
                    end else if (w_jump) begin
                        r_state <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (w_acked) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_jump) begin
                r_fetch_pc <= {bus.p3_jump_target[31:2], 2'b00};
            end
        end
    end

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = w_addr;
    assign bus.p2_instr  = w_q_empty ? c_NOP_INSTR : w_q_head.instr;
    assign bus.p2_pc     = w_q_empty ? r_fetch_pc  : w_q_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_cpu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_fetch
// Description : Self-checking bench for cpu_fetch: directed reset/stream/hold/
//               jump/wrap sequence with literal expectations, then randomized
//               pipeline control and memory latency against a queue model.
//               Honors FETCH_PREFETCH_EN for the expected buffer depth.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_fetch;

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [31:0] RST_PC = 32'hFFFF_0000;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_fetch_if bus ();

    cpu_fetch #(.RESET_ADDR(RST_PC)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Reference model: spec-level view of buffered words and fetch progress
    ent_t        mq[$];
    logic [31:0] m_fpc;
    bit          m_out;
    bit          m_disc;
    logic [31:0] m_oaddr;

    // Memory environment
    bit          mem_busy;
    int          mem_cnt;
    int          fixed_lat;
    logic [31:0] salt;

    int errors = 0;
    int checks = 0;

    logic        s_req;
    logic [31:0] s_addr, s_instr, s_pc;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'hFFFF_0000) return 32'h1234_5678;
        return a ^ salt;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, answer memory, compare, advance model
    task automatic step(input bit r, input bit st, input bit bb, input bit jp,
                        input logic [31:0] tg);
        bit          ack;
        bit          pop;
        bit          jmp;
        bit          e_req;
        logic [31:0] e_addr, e_instr, e_pc, d;
        rst                    = r;
        bus.stall              = st;
        bus.p2_pipeline_bubble = bb;
        bus.p3_jump            = jp;
        bus.p3_jump_target     = tg;
        bus.imem_ack           = 1'b0;
        #1;
        ack = 1'b0;
        if (r) begin
            mem_busy = 1'b0;
        end else if (bus.imem_req === 1'b1) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_cnt  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            end
            if (mem_cnt == 0) begin
                ack      = 1'b1;
                mem_busy = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        bus.imem_ack   = ack;
        bus.imem_rdata = ack ? mem_data(bus.imem_addr) : $urandom();
        #1;
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_instr = bus.p2_instr;
        s_pc    = bus.p2_pc;
        if (r) begin
            chk("req_in_reset", {31'd0, s_req}, 32'd0);
            mq.delete();
            m_fpc  = RST_PC;
            m_out  = 1'b0;
            m_disc = 1'b0;
        end else begin
            pop     = !st && !bb && !jp && (mq.size() > 0);
            jmp     = jp && !st;
            e_req   = m_out || (mq.size() < DEPTH) || pop;
            e_addr  = m_out ? m_oaddr : m_fpc;
            e_instr = (mq.size() > 0) ? mq[0].instr : 32'h0;
            e_pc    = (mq.size() > 0) ? mq[0].pc : m_fpc;
            chk("p2_instr", s_instr, e_instr);
            chk("p2_pc", s_pc, e_pc);
            chk("imem_req", {31'd0, s_req}, {31'd0, e_req});
            if (e_req) chk("imem_addr", s_addr, e_addr);
            if (pop) void'(mq.pop_front());
            if (e_req && ack) begin
                if (!m_disc && !jmp) begin
                    d = mem_data(e_addr);
                    mq.push_back('{instr: d, pc: e_addr});
                    m_fpc = e_addr + 32'd4;
                end
                m_out  = 1'b0;
                m_disc = 1'b0;
            end else if (e_req) begin
                m_out   = 1'b1;
                m_oaddr = e_addr;
                if (jmp) m_disc = 1'b1;
            end
            if (jmp) begin
                mq.delete();
                m_fpc = tg;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] tg;
        bit r, st, bb, jp;
        salt      = 32'h0;
        fixed_lat = 0;
        mem_busy  = 1'b0;
        mem_cnt   = 0;

        // Reset and first zero-wait fetch
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("lit_reset_req", {31'd0, s_req}, 32'd1);
        chk("lit_reset_addr", s_addr, 32'hFFFF_0000);
        chk("lit_reset_nop", s_instr, 32'h0000_0000);
        chk("lit_reset_pc", s_pc, 32'hFFFF_0000);
        step(0, 0, 0, 0, 0);
        chk("lit_first_instr", s_instr, 32'h1234_5678);
        chk("lit_first_pc", s_pc, 32'hFFFF_0000);

        // Stall three cycles while FFFF_0004 is presented
        step(0, 1, 0, 0, 0);
        chk("lit_stream_pc1", s_pc, 32'hFFFF_0004);
        chk("lit_stream_in1", s_instr, 32'hFFFF_0004);
        step(0, 1, 0, 0, 0);
        chk("lit_stall_pc", s_pc, 32'hFFFF_0004);
        chk("lit_stall_noreq", {31'd0, s_req}, 32'd0);
        step(0, 1, 0, 0, 0);
        chk("lit_stall_pc2", s_pc, 32'hFFFF_0004);
        chk("lit_stall_noreq2", {31'd0, s_req}, 32'd0);
        step(0, 0, 1, 0, 0);
        chk("lit_bubble_pc", s_pc, 32'hFFFF_0004);
        step(0, 0, 0, 0, 0);
        chk("lit_represent_pc", s_pc, 32'hFFFF_0004);
        step(0, 0, 0, 0, 0);
        chk("lit_stream_pc2", s_pc, 32'hFFFF_0008);

        // Jump while a 3-cycle-latency request is outstanding
        fixed_lat = 3;
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        fixed_lat = 0;
        step(0, 0, 0, 1, 32'h0000_0100);
        step(0, 0, 0, 0, 0);
        chk("lit_discard_addr", s_addr, 32'hFFFF_0000);
        chk("lit_discard_nop", s_instr, 32'h0000_0000);
        chk("lit_discard_pc", s_pc, 32'h0000_0100);
        step(0, 0, 0, 0, 0);
        chk("lit_discard_nop2", s_instr, 32'h0000_0000);
        step(0, 0, 0, 0, 0);
        chk("lit_target_req", {31'd0, s_req}, 32'd1);
        chk("lit_target_addr", s_addr, 32'h0000_0100);
        step(0, 0, 0, 1, 32'hFFFF_FFFC);
        chk("lit_target_pc", s_pc, 32'h0000_0100);
        chk("lit_target_instr", s_instr, 32'h0000_0100);

        // Wrap past the top of the address space
        step(0, 0, 0, 0, 0);
        chk("lit_wrap_nop", s_instr, 32'h0000_0000);
        step(0, 0, 0, 0, 0);
        chk("lit_wrap_pc_top", s_pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0);
        chk("lit_wrap_pc_zero", s_pc, 32'h0000_0000);

        // Randomized control with random memory latency, then zero-wait
        salt      = $urandom();
        fixed_lat = -1;
        for (int i = 0; i < 5000; i++) begin
            if (i == 4000) fixed_lat = 0;
            r  = ($urandom_range(0, 199) == 0);
            st = ($urandom_range(0, 3) == 0);
            bb = ($urandom_range(0, 6) == 0);
            jp = ($urandom_range(0, 11) == 0);
            tg = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) tg = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
            step(r, st, bb, jp, tg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_fetch.md
# cpu_fetch

Instruction fetch stage of the F32 pipeline. It generates the program counter, fetches 32-bit instruction words from instruction memory over a req/ack handshake, and buffers them. It presents one instruction per cycle to the decoder as `p2_instr`/`p2_pc`, holds on `stall` or `p2_pipeline_bubble`, and flushes and redirects on `p3_jump`.

## Interface
- `RESET_ADDR`, 32'hFFFF_0000: first fetch address after reset.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `stall` input 1: global pipeline stall; freezes the p2 output and blocks consumption.
- `p2_pipeline_bubble` input 1: decoder inserted a bubble; the current p2 instruction is re-presented next cycle.
- `p3_jump` input 1: taken branch or jump in p3; annuls p2 and redirects.
- `p3_jump_target` input 32: redirect address, word aligned.
- `p2_instr` output 32: instruction to the decoder.
- `p2_pc` output 32: address of `p2_instr`.
- `imem_req` output 1: memory request.
- `imem_addr` output 32: request address, word aligned.
- `imem_ack` input 1: request accepted and `imem_rdata` valid this cycle. Ack may arrive in the same cycle as the request or any later cycle.
- `imem_rdata` input 32: instruction word.

## Operation
- Registers:
  - `fetch_pc`: next address to request.
  - Instruction queue of {instr, pc} entries, depth 2.
  - Request state machine with three states: IDLE, WAIT, DISCARD.
- Memory protocol:
  - Once `imem_req` is raised, `imem_req` and `imem_addr` stay constant until the cycle `imem_ack`=1.
  - At most one request is outstanding.
- State machine:
  - IDLE: raise `imem_req` at `fetch_pc` when the queue has a free slot, counting a slot freed this cycle. Go to WAIT, or stay in IDLE if acked in the same cycle.
  - WAIT: hold the request. On ack, push {rdata, fetch_pc}, set `fetch_pc` += 4, and go to IDLE.
  - DISCARD: hold the old request. On ack, drop the data and go to IDLE.
- Output:
  - When the queue is non-empty, `p2_instr`/`p2_pc` = queue head.
  - When the queue is empty, `p2_instr` = NOP_INSTR (32'h0000_0000, which decodes to op 0) and `p2_pc` = `fetch_pc`.
- Consume: pop the head when `!stall && !p2_pipeline_bubble && !p3_jump` and the queue is non-empty.
- Jump (`p3_jump && !stall`):
  - Flush the queue and set `fetch_pc` = `p3_jump_target`.
  - A jump beats a same-cycle consume and a same-cycle ack push.
  - If a request is outstanding and not acked this cycle, go to DISCARD.
- `stall` high: no pop and no jump action. Memory requests continue into free slots.
- PC arithmetic: unsigned 32-bit, +4 wraps 32'hFFFF_FFFC → 32'h0000_0000.
- Reset: queue empty, `fetch_pc` = RESET_ADDR, state IDLE. The memory is reset by the same `reset`, so no stale ack follows.

## Timing
- Reset values:
  - `imem_req`=0 during the reset cycle; it asserts the cycle after.
  - `imem_addr`=RESET_ADDR.
  - `p2_instr`=NOP_INSTR.
  - `p2_pc`=RESET_ADDR.
- Latency with zero-wait memory (ack in the request cycle): the instruction appears on `p2_instr` the cycle after the ack.
- Jump at edge N:
  - Cycle N+1: target request.
  - Cycle N+2: target instruction on p2.
  - Each DISCARD adds the remaining wait cycles of the old request.
- Steady state with zero-wait memory: one instruction per cycle, no bubbles.
- Queue full: `imem_req`=0 until a pop.
- Simultaneous pop and push on a full queue are both accepted.

## Configuration
- `FETCH_PREFETCH_EN`:
  - Defined: 2-entry queue, and requests issue ahead of consumption.
  - Undefined: queue depth 1, and a request is issued only when the queue is empty or is being popped this cycle. Throughput is still 1/cycle with zero-wait memory; there is no slack under stall.

## Structure
- Shared package / `f32.vh`: NOP_INSTR, fetch state encodings, INSTR_BYTES=4.
- Sub-module `fetch_queue`:
  - Parameterised depth; push/pop/flush; `empty`/`full`/`free` flags.
  - Holds {instr, pc} and implements flush-beats-push priority.

## Test plan
- Reset: hold `reset` 2 cycles, release → `imem_req`=1, `imem_addr`=32'hFFFF_0000. With ack same cycle and `rdata`=32'h1234_5678 → next cycle `p2_instr`=32'h1234_5678, `p2_pc`=32'hFFFF_0000.
- Stream: zero-wait memory returning addr as data → `p2_pc` = FFFF_0000, FFFF_0004, FFFF_0008 on consecutive cycles, with no NOPs.
- Hold: `stall` for 3 cycles at `p2_pc`=FFFF_0004 → `p2_instr`/`p2_pc` unchanged and `imem_req`=0 once the queue is full. The same applies to `p2_pipeline_bubble` for 1 cycle.
- Jump with an outstanding request: ack delayed 3 cycles; `p3_jump` with target 32'h0000_0100 while waiting → old data dropped, next `imem_addr`=32'h0000_0100, `p2_instr`=NOP until the target data arrives, then `p2_pc`=32'h0000_0100.
- Wrap: jump to 32'hFFFF_FFFC → following `p2_pc` = FFFF_FFFC, then 0000_0000.
- Macro off: same stream, with a maximum of one buffered entry, and no `imem_req` while the head is held under `stall`.
